axis_fork_dispatch: RTL and testbench

//  Parametrised successor to the fixed 3-port fork arbiter. Steers one AXI4-Stream input to M_COUNT outputs.
//  Two modes, selected per packet:
//   - Broadcast: every beat goes to all enabled outputs.
//   - Dispatch: round-robin, whole packet to one enabled output.

---
 rtl/axis_fork_dispatch.sv | 146 ++++++++++++++
 tb/tb_axis_fork_dispatch.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fork_dispatch.sv
// axis_fork_dispatch: steers one AXI4-Stream input to M_COUNT outputs.
// Per packet, either broadcasts every beat to all enabled outputs or
// dispatches the whole packet round-robin to one enabled output.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   fork_enable           1=broadcast, 0=dispatch (sampled at packet start)
//   port_mask             enabled outputs (sampled at packet start)
//   s_axis_*              input stream (tready is combinational)
//   m_axis_*              output streams, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_packet             high between first accepted beat and accepted tlast
//   cur_port              dispatch target of the current/last packet
//   drop_pkt              one-cycle pulse after an empty-mask packet ends
module axis_fork_dispatch #(
  parameter int unsigned M_COUNT    = 4,
  parameter int unsigned DATA_WIDTH = 64,
  localparam int unsigned SEL_WIDTH = (M_COUNT > 1) ? $clog2(M_COUNT) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fork_enable,
  input  logic [M_COUNT-1:0]            port_mask,
  output logic                          s_axis_tready,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tlast,
  input  logic                          s_axis_tvalid,
  input  logic [M_COUNT-1:0]            m_axis_tready,
  output logic [M_COUNT*DATA_WIDTH-1:0] m_axis_tdata,
  output logic [M_COUNT-1:0]            m_axis_tlast,
  output logic [M_COUNT-1:0]            m_axis_tvalid,
  output logic                          in_packet,
  output logic [SEL_WIDTH-1:0]          cur_port,
  output logic                          drop_pkt
);

  logic [M_COUNT-1:0]    pend_q, pend_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;
  logic                  in_pkt_q, in_pkt_d;
  logic                  mode_q, mode_d;
  logic [M_COUNT-1:0]    mask_q, mask_d;
  logic [SEL_WIDTH-1:0]  rr_q, rr_d;
  logic [SEL_WIDTH-1:0]  cur_q, cur_d;
  logic                  drop_q, drop_d;

  logic                  accept;
  logic                  start;
  logic                  eff_mode;
  logic [M_COUNT-1:0]    eff_mask;
  logic [SEL_WIDTH-1:0]  eff_port;
  logic [SEL_WIDTH-1:0]  target;
  logic                  found;
  logic [SEL_WIDTH:0]    idx;
  logic [M_COUNT-1:0]    pend_new;

  // Input may advance only once every output still owing the held beat takes it.
  assign s_axis_tready = ((pend_q & ~m_axis_tready) == '0);
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign start         = accept & ~in_pkt_q;

  // At packet start the live mode/mask apply; afterwards the sampled copies.
  assign eff_mode = start ? fork_enable : mode_q;
  assign eff_mask = start ? port_mask : mask_q;

  // First enabled port strictly after the rr pointer, wrapping to 0.
  always_comb begin
    target = rr_q;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= int'(M_COUNT); k++) begin
      idx = {1'b0, rr_q} + (SEL_WIDTH+1)'(k);
      if (idx >= (SEL_WIDTH+1)'(M_COUNT)) idx = idx - (SEL_WIDTH+1)'(M_COUNT);
      if (!found && eff_mask[idx[SEL_WIDTH-1:0]]) begin
        found  = 1'b1;
        target = idx[SEL_WIDTH-1:0];
      end
    end
  end

  assign eff_port = (start && !fork_enable && found) ? target : cur_q;

  // Next-state logic for the holding register, pend vector and packet state.
  always_comb begin
    pend_d   = pend_q & ~m_axis_tready;
    data_d   = data_q;
    last_d   = last_q;
    in_pkt_d = in_pkt_q;
    mode_d   = mode_q;
    mask_d   = mask_q;
    rr_d     = rr_q;
    cur_d    = cur_q;
    drop_d   = 1'b0;
    pend_new = '0;

    if (eff_mode) pend_new = eff_mask;
    else if (eff_mask != '0) pend_new[eff_port] = 1'b1;

    if (start) begin
      mode_d = fork_enable;
      mask_d = port_mask;
      if (!fork_enable && found) begin
        rr_d  = target;
        cur_d = target;
      end
    end

    if (accept) begin
      data_d   = s_axis_tdata;
      last_d   = s_axis_tlast;
      pend_d   = pend_new;
      in_pkt_d = ~s_axis_tlast;
      drop_d   = s_axis_tlast & (eff_mask == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q   <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
      in_pkt_q <= 1'b0;
      mode_q   <= 1'b0;
      mask_q   <= '0;
      rr_q     <= SEL_WIDTH'(M_COUNT - 1);
      cur_q    <= '0;
      drop_q   <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      data_q   <= data_d;
      last_q   <= last_d;
      in_pkt_q <= in_pkt_d;
      mode_q   <= mode_d;
      mask_q   <= mask_d;
      rr_q     <= rr_d;
      cur_q    <= cur_d;
      drop_q   <= drop_d;
    end
  end

  assign m_axis_tvalid = pend_q;
  assign m_axis_tdata  = {M_COUNT{data_q}};
  assign m_axis_tlast  = {M_COUNT{last_q}};
  assign in_packet     = in_pkt_q;
  assign cur_port      = cur_q;
  assign drop_pkt      = drop_q;

endmodule

// File: tb/tb_axis_fork_dispatch.sv
// Self-checking bench for axis_fork_dispatch: per-port scoreboard queues
// filled from a reference model of input handshakes, drained by output
// handshakes, plus directed scenario checks.
module tb_axis_fork_dispatch;

  localparam int M  = 4;
  localparam int DW = 64;

  typedef logic [DW:0] beat_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            fork_enable = 1'b0;
  logic [M-1:0]    port_mask = '0;
  logic            s_axis_tready;
  logic [DW-1:0]   s_axis_tdata = '0;
  logic            s_axis_tlast = 1'b0;
  logic            s_axis_tvalid = 1'b0;
  logic [M-1:0]    m_axis_tready = '1;
  logic [M*DW-1:0] m_axis_tdata;
  logic [M-1:0]    m_axis_tlast;
  logic [M-1:0]    m_axis_tvalid;
  logic            in_packet;
  logic [1:0]      cur_port;
  logic            drop_pkt;

  axis_fork_dispatch #(.M_COUNT(M), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .fork_enable(fork_enable), .port_mask(port_mask),
    .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
    .in_packet(in_packet), .cur_port(cur_port), .drop_pkt(drop_pkt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  beat_t      sb_q [M][$];
  logic [1:0] rr_m = 2'd3;
  logic [1:0] cur_m = 2'd0;
  logic       in_pkt_m = 1'b0;
  logic       mode_m = 1'b0;
  logic [3:0] mask_m = 4'b0;
  logic       drop_m = 1'b0;
  logic       found_m;
  int         idx_m;
  int         drop_cnt = 0;
  beat_t      exp_b;
  beat_t      act_b;

  task automatic model_reset();
    for (int i = 0; i < M; i++) sb_q[i].delete();
    rr_m = 2'd3; cur_m = 2'd0; in_pkt_m = 1'b0; drop_m = 1'b0;
    mode_m = 1'b0; mask_m = 4'b0;
  endtask

  // Sample away from the active edge: compare outputs, then update the model.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (drop_pkt !== drop_m) begin
        errors++; $display("FAIL drop_pkt: got %b expected %b", drop_pkt, drop_m);
      end
      if (drop_pkt === 1'b1) drop_cnt++;
      checks++;
      if (in_packet !== in_pkt_m) begin
        errors++; $display("FAIL in_packet: got %b expected %b", in_packet, in_pkt_m);
      end
      checks++;
      if (cur_port !== cur_m) begin
        errors++; $display("FAIL cur_port: got %0d expected %0d", cur_port, cur_m);
      end
      checks++;
      if (s_axis_tready !== ((m_axis_tvalid & ~m_axis_tready) == 4'b0)) begin
        errors++; $display("FAIL s_tready: got %b with tvalid %b tready %b", s_axis_tready, m_axis_tvalid, m_axis_tready);
      end
      for (int i = 0; i < M; i++) begin
        if (m_axis_tvalid[i] === 1'b1) begin
          checks++;
          if (sb_q[i].size() == 0) begin
            errors++; $display("FAIL unexpected_valid: port %0d valid with no beat expected", i);
          end else if (m_axis_tready[i]) begin
            exp_b = sb_q[i].pop_front();
            act_b = {m_axis_tlast[i], m_axis_tdata[i*DW +: DW]};
            if (act_b !== exp_b) begin
              errors++; $display("FAIL port_beat: port %0d got %h expected %h", i, act_b, exp_b);
            end
          end
        end else if (m_axis_tvalid[i] !== 1'b0) begin
          checks++; errors++;
          $display("FAIL tvalid_x: port %0d tvalid=%b", i, m_axis_tvalid[i]);
        end
      end
      drop_m = 1'b0;
      if (s_axis_tvalid && s_axis_tready) begin
        if (!in_pkt_m) begin
          mode_m = fork_enable;
          mask_m = port_mask;
          if (!mode_m && mask_m != 4'b0) begin
            found_m = 1'b0;
            for (int k = 1; k <= M; k++) begin
              idx_m = (int'(rr_m) + k) % M;
              if (!found_m && mask_m[idx_m]) begin
                found_m = 1'b1; rr_m = 2'(idx_m); cur_m = 2'(idx_m);
              end
            end
          end
        end
        if (mask_m != 4'b0) begin
          if (mode_m) begin
            for (int i = 0; i < M; i++)
              if (mask_m[i]) sb_q[i].push_back({s_axis_tlast, s_axis_tdata});
          end else begin
            sb_q[cur_m].push_back({s_axis_tlast, s_axis_tdata});
          end
        end
        if (s_axis_tlast) begin
          in_pkt_m = 1'b0;
          if (mask_m == 4'b0) drop_m = 1'b1;
        end else begin
          in_pkt_m = 1'b1;
        end
      end
    end
  end

  // Drive one packet; mode/mask switch to the *_mid values after the first beat.
  task automatic send_pkt(input logic fe, input logic [3:0] mask, input int n,
                          input logic [7:0] tag, input logic fe_mid,
                          input logic [3:0] mask_mid, output int stalls);
    int  to;
    logic acc;
    stalls = 0;
    for (int b = 0; b < n; b++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = {tag, 48'h0, 8'(b)};
      s_axis_tlast  = (b == n - 1);
      fork_enable   = (b == 0) ? fe : fe_mid;
      port_mask     = (b == 0) ? mask : mask_mid;
      acc = 1'b0; to = 0;
      while (!acc && to < 100) begin
        @(negedge clk);
        if (s_axis_tready) acc = 1'b1; else stalls++;
        @(posedge clk); #1;
        to++;
      end
      if (!acc) begin
        checks++; errors++;
        $display("FAIL accept_timeout: tag %h beat %0d not accepted", tag, b);
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain();
    int to = 0;
    while ((sb_q[0].size() + sb_q[1].size() + sb_q[2].size() + sb_q[3].size()) != 0 && to < 200) begin
      @(posedge clk); #1; to++;
    end
    checks++;
    if ((sb_q[0].size() + sb_q[1].size() + sb_q[2].size() + sb_q[3].size()) != 0) begin
      errors++; $display("FAIL drain_timeout: beats still outstanding");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (m_axis_tvalid !== 4'b0 || m_axis_tdata !== '0 || m_axis_tlast !== 4'b0) begin
      errors++; $display("FAIL reset_outputs: tvalid %b tlast %b tdata %h expected zero", m_axis_tvalid, m_axis_tlast, m_axis_tdata);
    end
    checks++;
    if (in_packet !== 1'b0 || cur_port !== 2'd0 || drop_pkt !== 1'b0) begin
      errors++; $display("FAIL reset_status: in_packet %b cur_port %0d drop %b expected 0", in_packet, cur_port, drop_pkt);
    end
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++; $display("FAIL reset_tready: got %b expected 1", s_axis_tready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_broadcast();
    int st;
    m_axis_tready = 4'b1111;
    send_pkt(1'b1, 4'b1111, 3, 8'hA1, 1'b1, 4'b1111, st);
    checks++;
    if (st != 0) begin
      errors++; $display("FAIL bcast_stalls: got %0d expected 0", st);
    end
    @(negedge clk);
    checks++;
    if (m_axis_tvalid !== 4'b1111 || m_axis_tlast !== 4'b1111 || m_axis_tdata[3*DW +: DW] !== {8'hA1, 48'h0, 8'd2}) begin
      errors++; $display("FAIL bcast_last_beat: tvalid %b tlast %b data3 %h", m_axis_tvalid, m_axis_tlast, m_axis_tdata[3*DW +: DW]);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_backpressure();
    int st;
    m_axis_tready = 4'b1011;
    fork
      begin
        repeat (4) @(posedge clk);
        #1 m_axis_tready = 4'b1111;
      end
    join_none
    send_pkt(1'b1, 4'b0101, 2, 8'hB2, 1'b1, 4'b0101, st);
    checks++;
    if (st < 2) begin
      errors++; $display("FAIL bp_stalls: got %0d expected at least 2", st);
    end
    drain();
  endtask

  task automatic test_dispatch();
    int st;
    logic [1:0] exp_t [4];
    exp_t = '{2'd0, 2'd1, 2'd3, 2'd0};
    for (int p = 0; p < 4; p++) begin
      send_pkt(1'b0, 4'b1011, 2, 8'(8'hC0 + p), 1'b0, 4'b1011, st);
      checks++;
      if (cur_port !== exp_t[p]) begin
        errors++; $display("FAIL dispatch_target: pkt %0d got %0d expected %0d", p, cur_port, exp_t[p]);
      end
    end
    drain();
  endtask

  task automatic test_mode_switch();
    int st;
    send_pkt(1'b0, 4'b1011, 3, 8'hD4, 1'b1, 4'b1111, st);
    checks++;
    if (cur_port !== 2'd1) begin
      errors++; $display("FAIL switch_target: got %0d expected 1", cur_port);
    end
    send_pkt(1'b1, 4'b0110, 2, 8'hD5, 1'b1, 4'b0110, st);
    drain();
    checks++;
    if (cur_port !== 2'd1) begin
      errors++; $display("FAIL switch_bcast_cur: got %0d expected 1", cur_port);
    end
  endtask

  task automatic test_drop();
    int st;
    drop_cnt = 0;
    send_pkt(1'b0, 4'b0000, 2, 8'hE6, 1'b0, 4'b0000, st);
    checks++;
    if (st != 0) begin
      errors++; $display("FAIL drop_stalls: got %0d expected 0", st);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (drop_cnt != 1) begin
      errors++; $display("FAIL drop_pulses: got %0d expected 1", drop_cnt);
    end
    checks++;
    if (cur_port !== 2'd1) begin
      errors++; $display("FAIL drop_cur: got %0d expected 1", cur_port);
    end
    send_pkt(1'b0, 4'b1111, 1, 8'hE7, 1'b0, 4'b1111, st);
    checks++;
    if (cur_port !== 2'd2) begin
      errors++; $display("FAIL drop_rr_kept: got %0d expected 2", cur_port);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int st;
    int to;
    m_axis_tready = 4'b0000;
    s_axis_tvalid = 1'b1; s_axis_tdata = 64'hF0F0; s_axis_tlast = 1'b0;
    fork_enable = 1'b1; port_mask = 4'b0110;
    to = 0;
    do begin
      @(negedge clk); @(posedge clk); #1; to++;
    end while (!s_axis_tready && to < 10);
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (m_axis_tvalid !== 4'b0110 || in_packet !== 1'b1) begin
      errors++; $display("FAIL mid_pend: tvalid %b in_packet %b expected 0110/1", m_axis_tvalid, in_packet);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (m_axis_tvalid !== 4'b0 || in_packet !== 1'b0) begin
      errors++; $display("FAIL mid_reset: tvalid %b in_packet %b expected 0000/0", m_axis_tvalid, in_packet);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_axis_tready = 4'b1111;
    @(posedge clk); #1;
    send_pkt(1'b0, 4'b1100, 1, 8'hF1, 1'b0, 4'b1100, st);
    checks++;
    if (cur_port !== 2'd2) begin
      errors++; $display("FAIL post_reset_target: got %0d expected 2", cur_port);
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_broadcast();
    test_backpressure();
    test_dispatch();
    test_mode_switch();
    test_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
